// File: rtl/uart_ctrl_cfg_pkg.sv
// UART controller shared definitions: parity-mode encodings,
// FSM state encodings, oversample tick constants and a parity helper.
package uart_ctrl_cfg_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Mid-bit tick (start-bit check) and last tick of a 16-tick bit.
    localparam logic [3:0] TICK_MID = 4'd7;
    localparam logic [3:0] TICK_END = 4'd15;

    // Mode 2'b11 behaves as "no parity".
    function automatic logic par_en(input logic [1:0] m);
        return (m != PAR_NONE) && (m != 2'b11);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO, DEPTH = 2**AW, width DW.
// Ports: i_clk, i_reset (async, active-low), i_wr/i_w_data, i_rd, o_r_data, o_empty, o_full.
module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [DW-1:0] i_w_data,
    input  logic          i_rd,
    output logic [DW-1:0] o_r_data,
    output logic          o_empty,
    output logic          o_full
);

    localparam int PW = AW + 1;

    logic [DW-1:0] mem_q [2**AW];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic          do_wr, do_rd;

    // Extra pointer MSB distinguishes full from empty.
    assign o_empty = (wp_q == rp_q);
    assign o_full  = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);

    // A read in the same cycle frees a slot for a write when full.
    assign do_wr = i_wr && (!o_full || i_rd);
    assign do_rd = i_rd && !o_empty;

    assign wp_d = do_wr ? wp_q + PW'(1) : wp_q;
    assign rp_d = do_rd ? rp_q + PW'(1) : rp_q;

    assign o_r_data = o_empty ? '0 : mem_q[rp_q[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem_q[wp_q[AW-1:0]] <= i_w_data;
    end

endmodule

// File: rtl/uart_ctrl_cfg.sv
// Configurable UART: 16x oversampled RX/TX, RX/TX FIFOs, runtime baud divisor,
// parity/stop selection and sticky RX error flags.
// Ports: i_clk, i_reset (async active-low), i_dvsr, i_par_mode, i_stop2,
//  i_wr_uart/i_w_data, i_rd_uart, i_clr_err, i_rx, o_tx, o_r_data,
//  o_rx_empty, o_tx_full, o_tx_idle, o_par_err, o_frame_err, o_overrun.
// UART_LOOPBACK_EN: adds i_loopback; when 1 RX listens to TX and o_tx is held 1.
module uart_ctrl_cfg
    import uart_ctrl_cfg_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 8,
    parameter int FIFO_W   = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [DVSR_BIT-1:0] i_dvsr,
    input  logic [1:0]          i_par_mode,
    input  logic                i_stop2,
    input  logic                i_wr_uart,
    input  logic [DBIT-1:0]     i_w_data,
    input  logic                i_rd_uart,
    input  logic                i_clr_err,
`ifdef UART_LOOPBACK_EN
    input  logic                i_loopback,
`endif
    input  logic                i_rx,
    output logic                o_tx,
    output logic [DBIT-1:0]     o_r_data,
    output logic                o_rx_empty,
    output logic                o_tx_full,
    output logic                o_tx_idle,
    output logic                o_par_err,
    output logic                o_frame_err,
    output logic                o_overrun
);

    localparam int NW  = (DBIT > 2) ? $clog2(DBIT) : 1;
    localparam int SWC = $clog2(2 * SB_TICK);
    localparam int SW  = (SWC > 5) ? SWC : 5;

    function automatic logic calc_par(input logic [DBIT-1:0] d,
                                      input logic [1:0] m);
        return (m == PAR_ODD) ? ~^d : ^d;
    endfunction

    // Baud tick
    logic [DVSR_BIT-1:0] cnt_q, cnt_d;
    logic                tick;

    assign tick  = (cnt_q == i_dvsr);
    assign cnt_d = tick ? '0 : cnt_q + DVSR_BIT'(1);

    // RX state
    logic [2:0]      rst_q, rst_d;
    logic [3:0]      rs_q, rs_d;
    logic [NW-1:0]   rn_q, rn_d;
    logic [DBIT-1:0] rb_q, rb_d;
    logic            rpar_q, rpar_d;
    logic [1:0]      rmode_q, rmode_d;
    logic            rx_in, rx_push, rx_full;

    // TX state
    logic [2:0]      tst_q, tst_d;
    logic [SW-1:0]   ts_q, ts_d;
    logic [NW-1:0]   tn_q, tn_d;
    logic [DBIT-1:0] tb_q, tb_d;
    logic            tpar_q, tpar_d;
    logic [1:0]      tmode_q, tmode_d;
    logic            tstop2_q, tstop2_d;
    logic            tx_q, tx_d;
    logic            tx_pop, tx_empty;
    logic [DBIT-1:0] tx_head;
    logic [SW-1:0]   stop_last;

    // Error flags
    logic par_err_q, par_err_d;
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;
    logic par_set, frame_set, ovr_set;

`ifdef UART_LOOPBACK_EN
    assign rx_in = i_loopback ? tx_q : i_rx;
    assign o_tx  = i_loopback ? 1'b1 : tx_q;
`else
    assign rx_in = i_rx;
    assign o_tx  = tx_q;
`endif

    always_comb begin
        rst_d   = rst_q;
        rs_d    = rs_q;
        rn_d    = rn_q;
        rb_d    = rb_q;
        rpar_d  = rpar_q;
        rmode_d = rmode_q;
        rx_push = 1'b0;
        unique case (rst_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    rst_d   = ST_START;
                    rs_d    = '0;
                    rmode_d = i_par_mode;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rs_q == TICK_MID) begin
                        // Line went high again: treat as a glitch.
                        rst_d = rx_in ? ST_IDLE : ST_DATA;
                        rs_d  = '0;
                        rn_d  = '0;
                    end else begin
                        rs_d = rs_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (rs_q == TICK_END) begin
                        rs_d = '0;
                        rb_d = {rx_in, rb_q[DBIT-1:1]};
                        if (rn_q == NW'(DBIT - 1))
                            rst_d = par_en(rmode_q) ? ST_PAR : ST_STOP;
                        else
                            rn_d = rn_q + NW'(1);
                    end else begin
                        rs_d = rs_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    if (rs_q == TICK_END) begin
                        rs_d   = '0;
                        rpar_d = rx_in;
                        rst_d  = ST_STOP;
                    end else begin
                        rs_d = rs_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rs_q == TICK_END) begin
                        rx_push = 1'b1;
                        rst_d   = ST_IDLE;
                    end else begin
                        rs_d = rs_q + 4'd1;
                    end
                end
            end
            default: rst_d = ST_IDLE;
        endcase
    end

    // Errors are judged on the push attempt; the word is kept regardless.
    assign par_set   = rx_push && par_en(rmode_q) &&
                       (rpar_q != calc_par(rb_q, rmode_q));
    assign frame_set = rx_push && !rx_in;
    assign ovr_set   = rx_push && rx_full && !i_rd_uart;

    assign par_err_d   = (par_err_q   && !i_clr_err) || par_set;
    assign frame_err_d = (frame_err_q && !i_clr_err) || frame_set;
    assign overrun_d   = (overrun_q   && !i_clr_err) || ovr_set;

    assign stop_last = tstop2_q ? SW'(2 * SB_TICK - 1) : SW'(SB_TICK - 1);

    always_comb begin
        tst_d    = tst_q;
        ts_d     = ts_q;
        tn_d     = tn_q;
        tb_d     = tb_q;
        tpar_d   = tpar_q;
        tmode_d  = tmode_q;
        tstop2_d = tstop2_q;
        tx_d     = tx_q;
        tx_pop   = 1'b0;
        unique case (tst_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop   = 1'b1;
                    tst_d    = ST_START;
                    ts_d     = '0;
                    tb_d     = tx_head;
                    tmode_d  = i_par_mode;
                    tstop2_d = i_stop2;
                    tpar_d   = calc_par(tx_head, i_par_mode);
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (ts_q == SW'(TICK_END)) begin
                        tst_d = ST_DATA;
                        ts_d  = '0;
                        tn_d  = '0;
                        tx_d  = tb_q[0];
                    end else begin
                        ts_d = ts_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (ts_q == SW'(TICK_END)) begin
                        ts_d = '0;
                        tb_d = tb_q >> 1;
                        if (tn_q == NW'(DBIT - 1)) begin
                            if (par_en(tmode_q)) begin
                                tst_d = ST_PAR;
                                tx_d  = tpar_q;
                            end else begin
                                tst_d = ST_STOP;
                                tx_d  = 1'b1;
                            end
                        end else begin
                            tn_d = tn_q + NW'(1);
                            tx_d = tb_q[1];
                        end
                    end else begin
                        ts_d = ts_q + SW'(1);
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    if (ts_q == SW'(TICK_END)) begin
                        tst_d = ST_STOP;
                        ts_d  = '0;
                        tx_d  = 1'b1;
                    end else begin
                        ts_d = ts_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (ts_q == stop_last) tst_d = ST_IDLE;
                    else ts_d = ts_q + SW'(1);
                end
            end
            default: begin
                tst_d = ST_IDLE;
                tx_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q       <= '0;
            rst_q       <= ST_IDLE;
            rs_q        <= '0;
            rn_q        <= '0;
            rb_q        <= '0;
            rpar_q      <= 1'b0;
            rmode_q     <= PAR_NONE;
            tst_q       <= ST_IDLE;
            ts_q        <= '0;
            tn_q        <= '0;
            tb_q        <= '0;
            tpar_q      <= 1'b0;
            tmode_q     <= PAR_NONE;
            tstop2_q    <= 1'b0;
            tx_q        <= 1'b1;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rst_q       <= rst_d;
            rs_q        <= rs_d;
            rn_q        <= rn_d;
            rb_q        <= rb_d;
            rpar_q      <= rpar_d;
            rmode_q     <= rmode_d;
            tst_q       <= tst_d;
            ts_q        <= ts_d;
            tn_q        <= tn_d;
            tb_q        <= tb_d;
            tpar_q      <= tpar_d;
            tmode_q     <= tmode_d;
            tstop2_q    <= tstop2_d;
            tx_q        <= tx_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_par_err   = par_err_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_tx_idle   = (tst_q == ST_IDLE) && tx_empty;

    uart_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (rx_push),
        .i_w_data (rb_q),
        .i_rd     (i_rd_uart),
        .o_r_data (o_r_data),
        .o_empty  (o_rx_empty),
        .o_full   (rx_full)
    );

    uart_fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (i_wr_uart),
        .i_w_data (i_w_data),
        .i_rd     (tx_pop),
        .o_r_data (tx_head),
        .o_empty  (tx_empty),
        .o_full   (o_tx_full)
    );

endmodule

// File: tb/tb_uart_ctrl_cfg.sv
// Directed bench for uart_ctrl_cfg: DVSR=3 (64 clocks/bit), DBIT=8, FIFO_W=2.
// Outputs are sampled on the falling clock edge.
module tb_uart_ctrl_cfg;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_dvsr;
    logic [1:0] i_par_mode;
    logic       i_stop2;
    logic       i_wr_uart;
    logic [7:0] i_w_data;
    logic       i_rd_uart;
    logic       i_clr_err;
    logic       i_rx;
    logic       o_tx;
    logic [7:0] o_r_data;
    logic       o_rx_empty, o_tx_full, o_tx_idle;
    logic       o_par_err, o_frame_err, o_overrun;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_ctrl_cfg #(
        .DBIT(8), .SB_TICK(16), .DVSR_BIT(8), .FIFO_W(2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_dvsr      (i_dvsr),
        .i_par_mode  (i_par_mode),
        .i_stop2     (i_stop2),
        .i_wr_uart   (i_wr_uart),
        .i_w_data    (i_w_data),
        .i_rd_uart   (i_rd_uart),
        .i_clr_err   (i_clr_err),
`ifdef UART_LOOPBACK_EN
        .i_loopback  (1'b0),
`endif
        .i_rx        (i_rx),
        .o_tx        (o_tx),
        .o_r_data    (o_r_data),
        .o_rx_empty  (o_rx_empty),
        .o_tx_full   (o_tx_full),
        .o_tx_idle   (o_tx_idle),
        .o_par_err   (o_par_err),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic uwrite(input logic [7:0] d);
        @(negedge clk);
        i_wr_uart = 1'b1;
        i_w_data  = d;
        @(negedge clk);
        i_wr_uart = 1'b0;
    endtask

    task automatic upop();
        @(negedge clk);
        i_rd_uart = 1'b1;
        @(negedge clk);
        i_rd_uart = 1'b0;
    endtask

    task automatic clr_err();
        @(negedge clk);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
    endtask

    // Serial frame into i_rx, 64 clocks per bit. A zero stop bit is
    // held only 40 clocks so the line is high again well before the
    // receiver could re-qualify a start bit.
    task automatic rx_frame(input logic [7:0] d, input logic has_par,
                            input logic pbit, input logic sbit);
        i_rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            repeat (64) @(negedge clk);
        end
        if (has_par) begin
            i_rx = pbit;
            repeat (64) @(negedge clk);
        end
        i_rx = sbit;
        repeat (sbit ? 64 : 40) @(negedge clk);
        i_rx = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    logic [9:0]  exp_a5;
    logic [10:0] exp_01;
    logic [7:0]  exp_ovr [4];

    initial begin
        exp_a5     = 10'b1_1010_0101_0;
        exp_01     = 11'b1_1_0000_0001_0;
        exp_ovr[0] = 8'h11;
        exp_ovr[1] = 8'h22;
        exp_ovr[2] = 8'h33;
        exp_ovr[3] = 8'h44;

        i_reset    = 1'b0;
        i_dvsr     = 8'd3;
        i_par_mode = 2'b00;
        i_stop2    = 1'b0;
        i_wr_uart  = 1'b0;
        i_w_data   = 8'h00;
        i_rd_uart  = 1'b0;
        i_clr_err  = 1'b0;
        i_rx       = 1'b1;
        repeat (4) @(negedge clk);

        chk("rst_tx",       o_tx,        1);
        chk("rst_rx_empty", o_rx_empty,  1);
        chk("rst_tx_full",  o_tx_full,   0);
        chk("rst_tx_idle",  o_tx_idle,   1);
        chk("rst_par_err",  o_par_err,   0);
        chk("rst_frm_err",  o_frame_err, 0);
        chk("rst_overrun",  o_overrun,   0);
        chk("rst_r_data",   o_r_data,    0);
        i_reset = 1'b1;
        repeat (4) @(negedge clk);

        // TX 0xA5, no parity, one stop bit
        uwrite(8'hA5);
        chk("tx1_pre_start", o_tx, 1);
        chk("tx1_busy", o_tx_idle, 0);
        @(negedge clk);
        chk("tx1_start_lat", o_tx, 0);
        for (int k = 0; k < 10; k++) begin
            repeat (k == 0 ? 32 : 64) @(negedge clk);
            chk($sformatf("tx1_bit%0d", k), o_tx, exp_a5[k]);
        end
        chk("tx1_idle_in_stop", o_tx_idle, 0);
        repeat (40) @(negedge clk);
        chk("tx1_idle_end", o_tx_idle, 1);

        // TX 0x01, even parity, two stop bits; config change mid-frame
        i_par_mode = 2'b01;
        i_stop2    = 1'b1;
        uwrite(8'h01);
        @(negedge clk);
        chk("tx2_start_lat", o_tx, 0);
        i_par_mode = 2'b00;
        i_stop2    = 1'b0;
        for (int k = 0; k < 11; k++) begin
            repeat (k == 0 ? 32 : 64) @(negedge clk);
            chk($sformatf("tx2_bit%0d", k), o_tx, exp_01[k]);
        end
        repeat (64) @(negedge clk);
        chk("tx2_stop2_busy", o_tx_idle, 0);
        chk("tx2_stop2_line", o_tx, 1);
        repeat (40) @(negedge clk);
        chk("tx2_idle_end", o_tx_idle, 1);

        // RX 0x3C, even parity, parity bit 0 -> clean
        i_par_mode = 2'b01;
        rx_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        chk("rx1_empty", o_rx_empty, 0);
        chk("rx1_data", o_r_data, 8'h3C);
        chk("rx1_par_err", o_par_err, 0);
        chk("rx1_frm_err", o_frame_err, 0);
        upop();
        chk("rx1_popped", o_rx_empty, 1);

        // RX 0x01, odd parity with wrong parity bit (1), stop bit 0
        i_par_mode = 2'b10;
        rx_frame(8'h01, 1'b1, 1'b1, 1'b0);
        chk("rx2_empty", o_rx_empty, 0);
        chk("rx2_data", o_r_data, 8'h01);
        chk("rx2_par_err", o_par_err, 1);
        chk("rx2_frm_err", o_frame_err, 1);
        upop();
        chk("rx2_no_extra", o_rx_empty, 1);
        clr_err();
        chk("rx2_par_clr", o_par_err, 0);
        chk("rx2_frm_clr", o_frame_err, 0);

        // Five frames without reads: four kept, fifth dropped
        i_par_mode = 2'b00;
        rx_frame(8'h11, 1'b0, 1'b0, 1'b1);
        rx_frame(8'h22, 1'b0, 1'b0, 1'b1);
        rx_frame(8'h33, 1'b0, 1'b0, 1'b1);
        rx_frame(8'h44, 1'b0, 1'b0, 1'b1);
        chk("ovr_before_5th", o_overrun, 0);
        rx_frame(8'h55, 1'b0, 1'b0, 1'b1);
        chk("ovr_after_5th", o_overrun, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovr_data%0d", k), o_r_data, exp_ovr[k]);
            upop();
        end
        chk("ovr_drained", o_rx_empty, 1);
        clr_err();
        chk("ovr_clr", o_overrun, 0);

        // Start-bit glitch: low for 5 ticks, then a real frame
        i_rx = 1'b0;
        repeat (20) @(negedge clk);
        i_rx = 1'b1;
        repeat (80) @(negedge clk);
        chk("glitch_no_word", o_rx_empty, 1);
        rx_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("glitch_recover", o_r_data, 8'h5A);
        upop();

        // Fill TX FIFO, then reset in the middle of the DATA bits
        @(negedge clk);
        i_wr_uart = 1'b1;
        i_w_data  = 8'h00;
        repeat (5) @(negedge clk);
        i_wr_uart = 1'b0;
        chk("tx_full", o_tx_full, 1);
        repeat (200) @(negedge clk);
        chk("mid_data_low", o_tx, 0);
        #2;
        i_reset = 1'b0;
        #1;
        chk("arst_tx", o_tx, 1);
        chk("arst_tx_idle", o_tx_idle, 1);
        chk("arst_tx_full", o_tx_full, 0);
        chk("arst_rx_empty", o_rx_empty, 1);
        @(negedge clk);
        i_reset = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_line", o_tx, 1);
        chk("post_rst_idle", o_tx_idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
